udp_payload_arbiter: RTL and testbench
======================================

Name: udp_payload_arbiter

Overview:
- Shares one downstream byte-stream port between N_PORTS payload-forwarding streams, each coming from an independent UDP header-parse/forward pipeline.
- Arbitration is round-robin at packet granularity. Once a stream is granted, it holds the output until its last byte is accepted.
- The output is a registered valid/ready stage. The block sits between the per-channel forwarders and the shared egress (MAC/FIFO).

Parameters:
- N_PORTS, 4, number of requesting streams (2..8).
- DATA_W, 8, byte-lane width.
- CNT_W, 16, width of the per-port forwarded-packet counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_PORTS*DATA_W  payload bytes; stream i uses bits [i*DATA_W +: DATA_W].
- in_valid  in  N_PORTS  per-stream byte valid.
- in_last  in  N_PORTS  per-stream last-byte-of-packet flag; qualified by in_valid.
- in_ready  out  N_PORTS  per-stream accept; at most one bit high.
- out_data  out  DATA_W  registered output byte.
- out_valid  out  1  registered output valid.
- out_last  out  1  registered output last flag.
- out_ready  in  1  downstream accept.
- grant_id  out  $clog2(N_PORTS)  index of the current or most recent grant.
- busy  out  1  high while in LOCKED.
- pkt_done  out  1  one-cycle pulse when a last byte is accepted from the granted input.
- pkt_count  out  N_PORTS*CNT_W  per-port count of completed packets; saturating.

Behaviour:
- Reset (rst=1 at a clock edge) values:
  - state=IDLE.
  - out_valid=0, out_last=0, out_data=0.
  - in_ready=0, busy=0, pkt_done=0.
  - grant_id=N_PORTS-1, so the first arbitration favours port 0.
  - All pkt_count=0.
- Reset takes effect mid-packet: the partial packet is abandoned and no out_last is generated.
- States:
  - IDLE: no grant held.
  - LOCKED: one stream owns the output.
- IDLE -> LOCKED:
  - Occurs when any in_valid bit is set.
  - Winner is the first set in_valid bit scanning (grant_id+1) mod N_PORTS upward with wrap.
  - grant_id is registered to the winner on the same edge.
  - in_ready stays 0 in IDLE, giving a one-cycle arbitration bubble.
- LOCKED transfer rules:
  - in_ready[grant_id] = !out_valid || out_ready. All other in_ready bits are 0.
  - A beat is accepted when in_valid[g] && in_ready[g]. On the next edge out_data/out_last load from stream g and out_valid=1.
  - When out_ready=1 and no new beat is accepted, out_valid clears.
  - Throughput: one byte per cycle while out_ready is held high.
  - Input-to-output latency: 1 cycle.
- LOCKED -> IDLE:
  - Occurs on the edge that accepts a beat with in_last[g]=1.
  - The same edge pulses pkt_done and increments pkt_count[g].
  - The output register may still hold the last byte until out_ready drains it. A new grant is not blocked by this; the next grant's first beat waits on the same !out_valid||out_ready rule.
- pkt_count saturates at 2^CNT_W-1 and does not wrap.
- Boundary conditions:
  - in_valid dropping while LOCKED: the grant is held indefinitely. There is no timeout and no preemption.
  - Requests from non-granted ports are ignored until return to IDLE. Their in_valid may stay high, and their data must be held stable by the source.
  - Single-byte packet (in_last on the first beat): LOCKED lasts exactly one accepted beat.
  - Only one requester continuously active: it is re-granted after each IDLE bubble. Steady-state occupancy is (len)/(len+1).
  - Simultaneous requests: strict rotation; no port waits more than N_PORTS-1 packets.
  - out_ready low with the output register full: in_ready=0 and no beat is lost.
  - in_last on a non-granted port has no effect.

Test Plan:
- Reset, then port 0 sends 3 bytes 0xA1,0xA2,0xA3(last) with out_ready=1:
  - Output shows the same bytes on consecutive cycles, out_last with 0xA3.
  - pkt_done pulses once; pkt_count[0]=1; busy falls after the last accept.
- All 4 ports request simultaneously, each with a 2-byte packet:
  - Grants occur in order 0,1,2,3 and bytes are not interleaved.
  - Round 2 with ports 1 and 3 only: order 1,3.
- Port 2 sends a 4-byte packet while out_ready toggles 1,0,0,1,1,0,1:
  - No byte is dropped or duplicated; in_ready[2] is 0 exactly when out_valid=1 and out_ready=0.
- Port 1 grant held, in_valid[1] goes low for 5 cycles mid-packet while port 0 requests:
  - Grant stays on 1; port 0 is served only after port 1's last.
- rst asserted mid-packet on port 3:
  - Next cycle out_valid=0, busy=0, counters=0.
  - A new port-0 packet is granted first.
- With CNT_W=4, send 17 single-byte packets on port 0:
  - pkt_count[0] saturates at 15.
  - Each packet takes 2 cycles (grant bubble + beat).

Source files
------------

// File: rtl/udp_payload_arbiter_if.sv
// Byte-stream bundle between the per-channel payload forwarders and the shared egress.
// The master side drives the requests and the downstream accept; the slave side is the arbiter.
interface udp_payload_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 8
);
  logic [N_PORTS*DATA_W-1:0] in_data;
  logic [N_PORTS-1:0]        in_valid;
  logic [N_PORTS-1:0]        in_last;
  logic [N_PORTS-1:0]        in_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/udp_payload_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered byte-stream output
// between N_PORTS UDP payload forwarders, with per-port saturating packet counters.
module udp_payload_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  udp_payload_arbiter_if.slave       bus,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       busy,
  output logic                       pkt_done,
  output logic [N_PORTS*CNT_W-1:0]   pkt_count
);

  localparam int GW = $clog2(N_PORTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [N_PORTS-1:0]  ready_vec;
  logic [GW-1:0]       winner;
  logic [GW-1:0]       scan_idx;
  logic                found;
  logic                any_req;
  logic                accept;
  logic                accept_last;
  logic [DATA_W-1:0]   lane [N_PORTS];
  logic [CNT_W-1:0]    cnt  [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_lanes
    assign lane[g]                       = bus.in_data[g*DATA_W +: DATA_W];
    assign pkt_count[g*CNT_W +: CNT_W]   = cnt[g];
  end

  assign any_req     = |bus.in_valid;
  assign accept      = (state == LOCKED) && bus.in_valid[grant_id] && ready_vec[grant_id];
  assign accept_last = accept && bus.in_last[grant_id];
  assign bus.in_ready = ready_vec;

  // Rotating priority: scan upward from the port after the most recent grant.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    winner   = grant_id;
    found    = 1'b0;
    scan_idx = grant_id;
    for (int k = 1; k <= N_PORTS; k++) begin
      scan_idx = GW'((int'(grant_id) + k) % N_PORTS);
      if (!found && bus.in_valid[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)     state_nxt = LOCKED;
      LOCKED:  if (accept_last) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // The arbitration cycle in IDLE never accepts, which leaves the one-cycle grant bubble.
  always_comb begin
    ready_vec = '0;
    busy      = (state == LOCKED);
    if (state == LOCKED) ready_vec[grant_id] = !bus.out_valid || bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id      <= GW'(N_PORTS - 1);
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_valid <= 1'b0;
      pkt_done      <= 1'b0;
      // NOTE: the counter array is cleared element by element; reset covers it because software reads it.
      for (int i = 0; i < N_PORTS; i++) cnt[i] <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (state == IDLE && any_req) grant_id <= winner;
      if (accept) begin
        bus.out_data  <= lane[grant_id];
        bus.out_last  <= bus.in_last[grant_id];
        bus.out_valid <= 1'b1;
        if (bus.in_last[grant_id]) begin
          pkt_done <= 1'b1;
          if (cnt[grant_id] != '1) cnt[grant_id] <= cnt[grant_id] + 1'b1;
        end
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udp_payload_arbiter.sv
// Self-checking bench: queue-driven sources, a packet-level round-robin reference model,
// and an output monitor compared beat by beat and packet by packet.
module tb_udp_payload_arbiter;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int GW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic            pkt_done;
  logic [N*CW-1:0] pkt_count;

  udp_payload_arbiter_if #(.N_PORTS(N), .DATA_W(DW)) bus ();

  udp_payload_arbiter #(.N_PORTS(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  // Source side: one queue of {last,data} beats per port.
  logic [8:0]   src_q [N][$];
  logic [N-1:0] hold;
  int           rdy_mode;
  bit           rdy_pat [$];
  int           cyc;

  // Monitor side.
  logic [8:0]   obs_q [$];
  int           obs_cyc [$];
  int           obs_order [$];

  // Reference model: pending packets per port, rotation pointer, saturating counters.
  logic [8:0]   mdl_q [N][$];
  int           mdl_last;
  int           mdl_cnt [N];
  logic [8:0]   exp_q [$];
  int           exp_order [$];

  int n_assert;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && src_q[i].size() > 0) begin
        bus.in_valid[i]         = 1'b1;
        bus.in_data[i*DW +: DW] = src_q[i][0][7:0];
        bus.in_last[i]          = src_q[i][0][8];
      end else begin
        bus.in_valid[i] = 1'b0;
        bus.in_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic drive_ready();
    case (rdy_mode)
      1:       bus.out_ready = ($urandom_range(3) != 0);
      2:       bus.out_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      default: bus.out_ready = 1'b1;
    endcase
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: observe at the falling edge, then update sources just after the rising edge.
  task automatic tick();
    logic [N-1:0] pop;
    logic [N-1:0] exp_rdy;
    logic         live;
    logic         last_acc;
    @(negedge clk);
    live     = !rst;
    pop      = '0;
    last_acc = 1'b0;
    if (live) begin
      pop      = bus.in_valid & bus.in_ready;
      last_acc = |(pop & bus.in_last);
      check("ready_onehot", 64'($countones(bus.in_ready) <= 1), 64'(1));
      exp_rdy = '0;
      if (busy) exp_rdy[grant_id] = !(bus.out_valid && !bus.out_ready);
      check("ready_rule", 64'(bus.in_ready), 64'(exp_rdy));
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back({bus.out_last, bus.out_data});
        obs_cyc.push_back(cyc);
      end
      if (pkt_done) obs_order.push_back(int'(grant_id));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (live) begin
      check("pkt_done", 64'(pkt_done), 64'(last_acc));
      if (last_acc) check("busy_drop", 64'(busy), 64'(0));
    end
    for (int i = 0; i < N; i++) if (pop[i]) void'(src_q[i].pop_front());
    drive_src();
    drive_ready();
  endtask

  task automatic load_pkt(input int p, input int len, input logic [7:0] b0, input bit rnd);
    logic [7:0] b;
    for (int j = 0; j < len; j++) begin
      b = rnd ? 8'($urandom) : 8'(b0 + 8'(j));
      src_q[p].push_back({(j == len - 1), b});
      mdl_q[p].push_back({(j == len - 1), b});
    end
    drive_src();
  endtask

  // Serve every pending packet in strict rotation after the last granted port.
  task automatic model_drain();
    int p;
    logic [8:0] beat;
    forever begin
      p = -1;
      for (int k = 1; k <= N; k++)
        if (p < 0 && mdl_q[(mdl_last + k) % N].size() > 0) p = (mdl_last + k) % N;
      if (p < 0) break;
      do begin
        beat = mdl_q[p].pop_front();
        exp_q.push_back(beat);
      end while (!beat[8]);
      exp_order.push_back(p);
      if (mdl_cnt[p] < CNT_MAX) mdl_cnt[p]++;
      mdl_last = p;
    end
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((pending() || bus.out_valid || busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'(1));
  endtask

  task automatic compare_phase(input string tag);
    check({tag, "_beats"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    check({tag, "_pkts"}, 64'(obs_order.size()), 64'(exp_order.size()));
    for (int i = 0; i < obs_order.size() && i < exp_order.size(); i++)
      check($sformatf("%s_grant%0d", tag, i), 64'(obs_order[i]), 64'(exp_order[i]));
    for (int p = 0; p < N; p++)
      check($sformatf("%s_count%0d", tag, p), 64'(pkt_count[p*CW +: CW]), 64'(mdl_cnt[p]));
    obs_q.delete(); obs_cyc.delete(); obs_order.delete();
    exp_q.delete(); exp_order.delete();
  endtask

  task automatic model_reset();
    mdl_last = N - 1;
    for (int p = 0; p < N; p++) begin
      mdl_cnt[p] = 0;
      mdl_q[p].delete();
      src_q[p].delete();
    end
    obs_q.delete(); obs_cyc.delete(); obs_order.delete();
    exp_q.delete(); exp_order.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    hold     = '0;
    rdy_mode = 0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_last",  64'(bus.out_last),  64'(0));
    check("rst_out_data",  64'(bus.out_data),  64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(0));
    check("rst_busy",      64'(busy),          64'(0));
    check("rst_pkt_done",  64'(pkt_done),      64'(0));
    check("rst_grant_id",  64'(grant_id),      64'(N - 1));
    check("rst_pkt_count", 64'(pkt_count),     64'(0));

    // Port 0 three-byte packet at full throughput
    c0 = cyc;
    load_pkt(0, 3, 8'hA1, 1'b0);
    model_drain();
    run_drain(50);
    if (obs_cyc.size() == 3) begin
      check("t1_latency", 64'(obs_cyc[0] - c0), 64'(2));
      check("t1_back2back_a", 64'(obs_cyc[1] - obs_cyc[0]), 64'(1));
      check("t1_back2back_b", 64'(obs_cyc[2] - obs_cyc[1]), 64'(1));
    end
    compare_phase("t1");

    // All four ports at once, then ports 1 and 3
    for (int p = 0; p < N; p++) load_pkt(p, 2, 8'(8'h10 * p + 8'h80), 1'b0);
    model_drain();
    run_drain(100);
    compare_phase("t2a");
    load_pkt(1, 2, 8'h51, 1'b0);
    load_pkt(3, 2, 8'h53, 1'b0);
    model_drain();
    run_drain(100);
    compare_phase("t2b");

    // Port 2 under a stalling downstream
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rdy_mode = 2;
    load_pkt(2, 4, 8'hC0, 1'b0);
    model_drain();
    run_drain(100);
    compare_phase("t3");
    rdy_mode = 0;

    // Port 1 stalls mid-packet while port 0 requests
    load_pkt(1, 4, 8'hD0, 1'b0);
    model_drain();
    n = 0;
    while (src_q[1].size() == 4 && n < 20) begin
      tick();
      n++;
    end
    check("t4_start_timeout", 64'(n < 20), 64'(1));
    hold[1] = 1'b1;
    load_pkt(0, 2, 8'hE0, 1'b0);
    model_drain();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_grant", 64'(grant_id), 64'(1));
      check("t4_hold_busy",  64'(busy),     64'(1));
    end
    hold[1] = 1'b0;
    drive_src();
    run_drain(100);
    compare_phase("t4");

    // Randomized rounds with random downstream back-pressure
    rdy_mode = 1;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < N; p++) begin
        n = $urandom_range(2);
        for (int k = 0; k < n; k++) load_pkt(p, $urandom_range(5, 1), 8'h00, 1'b1);
      end
      model_drain();
      run_drain(400);
      compare_phase($sformatf("rnd%0d", r));
    end
    rdy_mode = 0;

    // Reset in the middle of a port 3 packet
    load_pkt(3, 6, 8'h30, 1'b0);
    n = 0;
    while (src_q[3].size() > 3 && n < 20) begin
      tick();
      n++;
    end
    check("t5_start_timeout", 64'(n < 20), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_out_valid", 64'(bus.out_valid), 64'(0));
    check("t5_busy",      64'(busy),          64'(0));
    check("t5_counts",    64'(pkt_count),     64'(0));
    check("t5_grant_id",  64'(grant_id),      64'(N - 1));
    model_reset();
    drive_src();
    load_pkt(3, 2, 8'h38, 1'b0);
    load_pkt(0, 2, 8'h08, 1'b0);
    model_drain();
    run_drain(100);
    compare_phase("t5");

    // Seventeen single-byte packets on port 0: two cycles each, counter saturates
    for (int k = 0; k < 17; k++) load_pkt(0, 1, 8'(8'h60 + k), 1'b0);
    model_drain();
    run_drain(200);
    for (int i = 1; i < obs_cyc.size(); i++)
      check($sformatf("t6_spacing%0d", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'(2));
    check("t6_saturated", 64'(pkt_count[CW-1:0]), 64'(CNT_MAX));
    compare_phase("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
